// File: rtl/ex_muldiv_if.sv
// Handshake and result bus between the EX-stage operand select and the mul/div unit.
interface ex_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             mthi;
  logic             mtlo;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, X, Y, mthi, mtlo, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, X, Y, mthi, mtlo, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative 32-cycle shift-add multiplier / restoring divider owning the HI/LO registers.
// Operands are reduced to magnitudes on launch; signs are reapplied when the result commits.
module ex_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  ex_muldiv_if.slave  bus
);
  localparam int unsigned DW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] opnd;
  logic [DW-1:0]    acc;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             load, step, commit, wr_hi, wr_lo;
  logic             sx, sy;
  logic [WIDTH-1:0] x_mag, y_mag;
  logic [WIDTH:0]   mul_sum;
  logic [DW-1:0]    mul_next;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic [DW-1:0]    div_next;
  logic [DW-1:0]    prod;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next state plus the datapath strobes; flush wins over everything else.
  always_comb begin
    state_d = state;
    load    = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.flush) begin
          if (bus.start) begin
            load    = 1'b1;
            state_d = RUN;
          end else begin
            wr_hi = bus.mthi;
            wr_lo = bus.mtlo;
          end
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (cnt == '0) state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
        commit  = !bus.flush;
      end
      default: state_d = IDLE;
    endcase
  end

  // Signed ops (op[0]==0) work on magnitudes.
  always_comb begin
    sx    = ~bus.op[0] & bus.X[WIDTH-1];
    sy    = ~bus.op[0] & bus.Y[WIDTH-1];
    x_mag = sx ? -bus.X : bus.X;
    y_mag = sy ? -bus.Y : bus.Y;
  end

  // One multiply step: conditional add into the upper half, then shift right.
  always_comb begin
    mul_sum  = {1'b0, acc[DW-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  // One restoring-divide step: shift remainder/quotient left, trial subtract on 33 bits.
  always_comb begin
    shifted  = {acc[DW-1:WIDTH], acc[WIDTH-1]};
    trial    = {1'b0, shifted} - {2'b00, opnd};
    div_next = trial[WIDTH+1] ? {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                              : {trial[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};
  end

  // Sign correction; a zero divisor yields all-ones quotient and the signed dividend.
  always_comb begin
    prod = neg_q ? -acc : acc;
    if (is_div) begin
      res_hi = neg_r ? -acc[DW-1:WIDTH] : acc[DW-1:WIDTH];
      if (opnd == '0)  res_lo = '1;
      else if (neg_q)  res_lo = -acc[WIDTH-1:0];
      else             res_lo = acc[WIDTH-1:0];
    end else begin
      res_hi = prod[DW-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
    end else if (load) begin
      cnt    <= CNT_W'(WIDTH - 1);
      is_div <= bus.op[1];
      neg_q  <= sx ^ sy;
      neg_r  <= sx;
      opnd   <= bus.op[1] ? y_mag : x_mag;
      acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? x_mag : y_mag)};
    end else if (step) begin
      cnt    <= cnt - 1'b1;
      acc    <= is_div ? div_next : mul_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      busy_q <= (state_d != IDLE);
      done_q <= commit;
      if (commit) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else begin
        if (wr_hi) hi_q <= bus.X;
        if (wr_lo) lo_q <= bus.X;
      end
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: vector table for arithmetic results plus hand-written
// sequences for MTHI/MTLO, flush, start-while-busy and mid-operation reset.
module tb_ex_muldiv;
  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   bc;
  logic dn;
  vec_t vecs [11];

  ex_muldiv_if #(.WIDTH(32)) ifc ();

  ex_muldiv #(.WIDTH(32), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Called at a negedge; presents the operation for exactly one rising edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    ifc.op    = o;
    ifc.X     = x;
    ifc.Y     = y;
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  // Counts busy cycles (bounded); dn is set only if done appears after busy drops, never before.
  task automatic wait_done(output int bcnt, output logic d);
    logic early;
    early = 1'b0;
    bcnt  = 0;
    while (ifc.busy === 1'b1 && bcnt < 40) begin
      if (ifc.done !== 1'b0) early = 1'b1;
      bcnt++;
      @(negedge clk);
    end
    d = (ifc.done === 1'b1) && !early;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk    = 1'b0;
    rst_n  = 1'b0;
    ifc.start = 1'b0; ifc.op = 2'b00; ifc.X = '0; ifc.Y = '0;
    ifc.mthi  = 1'b0; ifc.mtlo = 1'b0; ifc.flush = 1'b0;

    vecs[0]  = '{MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1]  = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[3]  = '{DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4]  = '{DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[5]  = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6]  = '{DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[7]  = '{DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8]  = '{MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[9]  = '{DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[10] = '{MULT,  32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000};

    repeat (2) @(negedge clk);
    chk("reset_hi",   64'(ifc.hi),   64'h0);
    chk("reset_lo",   64'(ifc.lo),   64'h0);
    chk("reset_busy", 64'(ifc.busy), 64'h0);
    chk("reset_done", 64'(ifc.done), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      launch(vecs[i].op, vecs[i].x, vecs[i].y);
      wait_done(bc, dn);
      chk($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'd33);
      chk($sformatf("vec%0d_done", i),        64'(dn), 64'd1);
      chk($sformatf("vec%0d_hi", i),          64'(ifc.hi), 64'(vecs[i].hi));
      chk($sformatf("vec%0d_lo", i),          64'(ifc.lo), 64'(vecs[i].lo));
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i),  64'(ifc.done), 64'd0);
    end

    // MTHI then MTLO in IDLE
    ifc.X = 32'h1234_5678; ifc.mthi = 1'b1;
    @(negedge clk);
    ifc.mthi = 1'b0;
    chk("mthi_hi", 64'(ifc.hi), 64'h1234_5678);
    ifc.X = 32'hAAAA_5555; ifc.mtlo = 1'b1;
    @(negedge clk);
    ifc.mtlo = 1'b0;
    chk("mtlo_lo", 64'(ifc.lo), 64'hAAAA_5555);
    chk("mtlo_hi_kept", 64'(ifc.hi), 64'h1234_5678);

    // start with MTLO in the same cycle, then MTLO held during RUN
    ifc.mtlo = 1'b1;
    launch(MULTU, 32'd3, 32'd4);
    chk("start_mtlo_dropped", 64'(ifc.lo), 64'hAAAA_5555);
    chk("start_mtlo_busy",    64'(ifc.busy), 64'd1);
    ifc.X = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    chk("run_mtlo_ignored", 64'(ifc.lo), 64'hAAAA_5555);
    ifc.mtlo = 1'b0;
    wait_done(bc, dn);
    chk("start_mtlo_cycles", 64'(bc), 64'd30);
    chk("start_mtlo_done", 64'(dn), 64'd1);
    chk("start_mtlo_res_lo", 64'(ifc.lo), 64'h0000_000C);
    chk("start_mtlo_res_hi", 64'(ifc.hi), 64'h0);
    @(negedge clk);

    // Flush in RUN at cycle +10
    ifc.X = 32'h5A5A_0001; ifc.mthi = 1'b1; ifc.mtlo = 1'b1;
    @(negedge clk);
    ifc.mthi = 1'b0; ifc.mtlo = 1'b0;
    chk("mthi_mtlo_hi", 64'(ifc.hi), 64'h5A5A_0001);
    chk("mthi_mtlo_lo", 64'(ifc.lo), 64'h5A5A_0001);
    launch(MULTU, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    ifc.flush = 1'b1;
    @(negedge clk);
    ifc.flush = 1'b0;
    chk("flush_run_busy", 64'(ifc.busy), 64'd0);
    chk("flush_run_done", 64'(ifc.done), 64'd0);
    repeat (3) @(negedge clk);
    chk("flush_run_idle_done", 64'(ifc.done), 64'd0);
    chk("flush_run_hi", 64'(ifc.hi), 64'h5A5A_0001);
    chk("flush_run_lo", 64'(ifc.lo), 64'h5A5A_0001);
    launch(MULTU, 32'd3, 32'd4);
    wait_done(bc, dn);
    chk("after_flush_done", 64'(dn), 64'd1);
    chk("after_flush_lo", 64'(ifc.lo), 64'h0000_000C);
    @(negedge clk);

    // Flush while in FIN suppresses the write
    ifc.X = 32'h0BAD_F00D; ifc.mthi = 1'b1; ifc.mtlo = 1'b1;
    @(negedge clk);
    ifc.mthi = 1'b0; ifc.mtlo = 1'b0;
    launch(MULTU, 32'd3, 32'd4);
    repeat (32) @(negedge clk);
    chk("fin_busy", 64'(ifc.busy), 64'd1);
    ifc.flush = 1'b1;
    @(negedge clk);
    ifc.flush = 1'b0;
    chk("flush_fin_busy", 64'(ifc.busy), 64'd0);
    chk("flush_fin_done", 64'(ifc.done), 64'd0);
    chk("flush_fin_hi", 64'(ifc.hi), 64'h0BAD_F00D);
    chk("flush_fin_lo", 64'(ifc.lo), 64'h0BAD_F00D);

    // Flush in IDLE blocks start and MTHI
    ifc.flush = 1'b1; ifc.start = 1'b1; ifc.mthi = 1'b1;
    ifc.op = MULTU; ifc.X = 32'h77; ifc.Y = 32'h1;
    @(negedge clk);
    ifc.flush = 1'b0; ifc.start = 1'b0; ifc.mthi = 1'b0;
    chk("flush_idle_busy", 64'(ifc.busy), 64'd0);
    chk("flush_idle_hi", 64'(ifc.hi), 64'h0BAD_F00D);
    @(negedge clk);
    chk("flush_idle_busy2", 64'(ifc.busy), 64'd0);

    // start while busy is ignored
    launch(MULTU, 32'd2, 32'd3);
    ifc.start = 1'b1; ifc.op = DIVU; ifc.X = 32'd5; ifc.Y = 32'd1;
    @(negedge clk);
    ifc.start = 1'b0;
    wait_done(bc, dn);
    chk("busy_start_cycles", 64'(bc), 64'd32);
    chk("busy_start_done", 64'(dn), 64'd1);
    chk("busy_start_lo", 64'(ifc.lo), 64'h6);
    chk("busy_start_hi", 64'(ifc.hi), 64'h0);
    @(negedge clk);

    // Reset mid-operation
    launch(DIV, 32'hFFFF_FFF9, 32'h2);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_hi",   64'(ifc.hi),   64'h0);
    chk("midreset_lo",   64'(ifc.lo),   64'h0);
    chk("midreset_busy", 64'(ifc.busy), 64'h0);
    chk("midreset_done", 64'(ifc.done), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch(DIVU, 32'd100, 32'd7);
    wait_done(bc, dn);
    chk("post_reset_cycles", 64'(bc), 64'd33);
    chk("post_reset_done", 64'(dn), 64'd1);
    chk("post_reset_lo", 64'(ifc.lo), 64'hE);
    chk("post_reset_hi", 64'(ifc.hi), 64'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the ALU operand-select logic.
- Consumes the selected X (rs value) and Y (second-operand mux output) for MULT/MULTU/DIV/DIVU.
- Runs a 32-iteration shift-add multiply or restoring divide and writes the architectural HI/LO registers.
- Drives a busy/stall signal to hold the pipeline; also services MTHI/MTLO writes and feeds MFHI/MFLO reads.

Parameters:
- WIDTH, 32: operand and HI/LO width; only 32 is supported and verified.
- CNT_W, 5: iteration counter width, log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  launch operation; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- X  input  WIDTH  first operand; dividend or multiplicand.
- Y  input  WIDTH  second operand; divisor or multiplier.
- mthi  input  1  write X into HI; accepted only in IDLE.
- mtlo  input  1  write X into LO; accepted only in IDLE.
- flush  input  1  abort any in-flight operation.
- busy  output  1  high while an operation is in progress; pipeline stall request.
- done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, all internal operand/accumulator registers 0. A reset mid-operation discards the operation.
- FSM states: IDLE, RUN, FIN.
  - IDLE -> RUN on start=1 and flush=0. Latch op, the sign flags, |X| and |Y|; counter=31. Signed ops take magnitudes; unsigned ops pass operands unchanged.
  - RUN: one iteration per cycle; counter decrements; RUN -> FIN when counter==0 (32 RUN cycles).
  - FIN: apply sign correction, write hi/lo, done=1 for this cycle only; FIN -> IDLE.
- Latency: start in cycle N -> done and new hi/lo visible in cycle N+33.
- busy: registered; 1 in RUN and FIN, 0 in IDLE. Upstream must hold the instruction while busy=1.
- Multiply:
  - 64-bit product {hi,lo}.
  - MULT: negate the product if sign(X) xor sign(Y).
- Divide:
  - Restoring, 33-bit trial subtract; lo=quotient, hi=remainder.
  - DIV: quotient negated if the signs differ; remainder takes the dividend's sign.
  - Divisor 0, both DIV and DIVU: lo=FFFF_FFFF, hi=X as latched; no sign correction.
  - DIV 8000_0000 / FFFF_FFFF: lo=8000_0000, hi=0000_0000, no trap.
- MTHI/MTLO:
  - In IDLE with start=0: hi or lo <= X on the next edge; mthi and mtlo together write both.
  - Ignored in RUN/FIN.
  - start and mthi/mtlo in the same cycle: start wins, the write is dropped.
- flush:
  - In RUN or FIN: state -> IDLE on the next edge, no done, hi/lo unchanged (a flush in FIN suppresses the write).
  - In IDLE: blocks start and mthi/mtlo for that cycle.
- start while busy: ignored; no queueing.
- hi/lo change only on reset, an MTHI/MTLO write, or FIN.

Test Plan:
- MULT X=FFFF_FFFD (-3), Y=0000_0005 -> done at cycle +33; hi=FFFF_FFFF, lo=FFFF_FFF1; busy high for exactly 33 cycles.
- MULTU X=Y=FFFF_FFFF -> hi=FFFF_FFFE, lo=0000_0001. Then MULT with the same operands -> hi=0000_0000, lo=0000_0001.
- DIV X=FFFF_FFF9 (-7), Y=2 -> lo=FFFF_FFFD, hi=FFFF_FFFF. DIVU X=7, Y=0 -> lo=FFFF_FFFF, hi=0000_0007. DIV 8000_0000 / FFFF_FFFF -> lo=8000_0000, hi=0.
- MTHI X=1234_5678 in IDLE -> hi=1234_5678. Then start with MTLO asserted in the same cycle -> MTLO dropped, operation runs. MTLO during RUN -> ignored.
- Start MULTU 3*4, flush at cycle +10 -> busy=0 next cycle, no done, hi/lo retain prior values. Next start runs normally (lo=0000_000C).
- Start DIV, drop rst_n at cycle +15 -> hi=lo=0 and busy=0 immediately. After release, start accepted.
